// File: rtl/exu_dmem_resp_if.sv
// Load/store request bus between the execution unit (master) and the
// data-memory responder (slave).
interface exu_dmem_resp_if;
   logic        req_i;
   logic        we_i;
   logic [31:0] raddr_i;
   logic [31:0] waddr_i;
   logic [31:0] wdata_i;
   logic        abort_i;
   logic [31:0] rdata_o;
   logic        hold_o;
   logic        err_o;

   modport master (
      output req_i, we_i, raddr_i, waddr_i, wdata_i, abort_i,
      input  rdata_o, hold_o, err_o
   );

   modport slave (
      input  req_i, we_i, raddr_i, waddr_i, wdata_i, abort_i,
      output rdata_o, hold_o, err_o
   );
endinterface

// File: rtl/exu_dmem_resp.sv
// Data-side memory responder: word-addressed SRAM behind a wait-state counter,
// stalling the pipeline via hold_o and flagging out-of-range accesses.
module exu_dmem_resp #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   exu_dmem_resp_if.slave   bus
);

   localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               we_q;
   logic               in_range_q;
   logic [IDX_W-1:0]   idx_q;
   logic [31:0]        wdata_q;
   logic [31:0]        rdata_q;
   logic [31:0]        mem_q [DEPTH_WORDS];

   logic [31:0]        addr_in;
   logic [31:0]        offset_in;
   logic               inr_in;
   logic [IDX_W-1:0]   idx_in;
   logic               capture, commit, hold, err;
   logic               acc_we, acc_inr, rd_fire;
   logic [IDX_W-1:0]   acc_idx;

   // Unsigned wrap makes addresses below the base land far above SPAN,
   // so a single compare covers both range bounds.
   assign addr_in   = bus.we_i ? bus.waddr_i : bus.raddr_i;
   assign offset_in = addr_in - ADDR_BASE;
   assign inr_in    = (offset_in < SPAN);
   assign idx_in    = IDX_W'(offset_in >> 2);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      commit  = 1'b0;
      hold    = 1'b0;
      err     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_i && !bus.abort_i) begin
               capture = 1'b1;
               hold    = 1'b1;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES != 0) ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            hold = 1'b1;
            if (bus.abort_i) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_d = S_RESP;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            if (!bus.abort_i) begin
               err    = !in_range_q;
               commit = we_q && in_range_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // With zero wait states the read lands straight from IDLE, before the
   // capture registers are loaded, so the live request is used there.
   assign acc_we  = (state_q == S_IDLE) ? bus.we_i : we_q;
   assign acc_inr = (state_q == S_IDLE) ? inr_in   : in_range_q;
   assign acc_idx = (state_q == S_IDLE) ? idx_in   : idx_q;
   assign rd_fire = (state_d == S_RESP) && (state_q != S_RESP) && !acc_we;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (rd_fire) rdata_q <= acc_inr ? mem_q[acc_idx] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         we_q       <= bus.we_i;
         idx_q      <= idx_in;
         in_range_q <= inr_in;
         wdata_q    <= bus.wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (commit) mem_q[idx_q] <= wdata_q;
   end

   // Gated by reset so a pending request cannot stall ctrl while in reset.
   assign bus.hold_o  = hold && rst;
   assign bus.err_o   = err;
   assign bus.rdata_o = rdata_q;

endmodule

// File: doc/exu_dmem_resp.md
# exu_dmem_resp

Data-side memory responder that services the load/store request interface driven by the execution unit (`mem_req_o`, `mem_we_o`, `mem_raddr_o`, `mem_waddr_o`, `mem_wdata_o`) and returns `mem_rdata_i`. It owns a word-addressed data SRAM behind a configurable wait-state counter. It stalls the pipeline through a hold flag to the ctrl block until the access completes, and it flags out-of-range accesses. An abort input lets the interrupt/flush path cancel an in-flight access without side effects.

## Interface
- `DEPTH_WORDS`, 4096: number of 32-bit words in the array; must be a power of two.
- `ADDR_BASE`, 32'h1000_0000: byte address of word 0; must be aligned to 4*DEPTH_WORDS.
- `WAIT_CYCLES`, 1: extra wait cycles inserted before the response cycle; valid range 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (`RstEnable` = 0).
- `req_i`  in  1  access request from the execution unit.
- `we_i`  in  1  1 = write, 0 = read.
- `raddr_i`  in  32  read byte address.
- `waddr_i`  in  32  write byte address.
- `wdata_i`  in  32  write data; full word, no byte strobes.
- `abort_i`  in  1  cancel the in-flight access; driven from the interrupt-assert path.
- `rdata_o`  out  32  read data returned to the execution unit.
- `hold_o`  out  1  stall request to ctrl.
- `err_o`  out  1  out-of-range access indication; valid in the response cycle only.

## Operation
- FSM with three states: IDLE, WAIT, RESP.
- Effective address: `waddr_i` if `we_i`, else `raddr_i`. Bits [1:0] are ignored. Index = (addr − ADDR_BASE) >> 2.
- An address is in range iff ADDR_BASE ≤ addr < ADDR_BASE + 4*DEPTH_WORDS.
- IDLE, on `req_i`=1 and `abort_i`=0:
  - capture we, index, in-range flag and wdata.
  - load `cnt` with WAIT_CYCLES.
  - next state is WAIT if WAIT_CYCLES > 0, else RESP.
- IDLE, on `req_i`=0 or `abort_i`=1: remain in IDLE, capture nothing.
- WAIT: decrement `cnt` each cycle. When `cnt`=1, next state is RESP.
- On the edge entering RESP, for a read: `rdata_o` <= mem[index] if in range, else 0.
- RESP:
  - `err_o` = !in_range.
  - Write commits mem[index] <= wdata on the RESP→IDLE edge, only if in range.
  - An out-of-range write is dropped.
  - Next state is unconditionally IDLE.
- Abort: `abort_i`=1 while in WAIT or RESP forces IDLE on the next edge.
  - No write commit; `err_o` forced 0 in that cycle.
  - `rdata_o` keeps its last value.
- `hold_o` is combinational: asserted in IDLE when (`req_i` && !`abort_i`), and in WAIT; deasserted in RESP.
- `rdata_o` holds its value until the next read enters RESP; a write does not change it.
- The array is not reset; its contents after reset are undefined.
- Read-after-write: a read issued in the transaction after a write to the same index returns the new data.

## Timing
- Reset values: state=IDLE, `cnt`=0, `rdata_o`=0, `err_o`=0, `hold_o`=0 (also when `req_i`=1 under reset).
- Reset asserted mid-operation: immediate return to IDLE; any pending write is lost; outputs go to reset values asynchronously.
- Access accepted in IDLE at cycle 0:
  - cycles 0..WAIT_CYCLES: `hold_o`=1.
  - cycle WAIT_CYCLES+1: RESP, with `hold_o`=0 and `rdata_o`/`err_o` valid.
  - Total pipeline stall = WAIT_CYCLES+1 cycles.
- WAIT_CYCLES=0: IDLE → RESP; one stall cycle; data valid in the cycle after acceptance.
- The requester holds `req_i`, `we_i` and the addresses stable while `hold_o`=1. The responder ignores changes after capture.
- Back-to-back accesses: a new request can be accepted in the IDLE cycle immediately after RESP. There is no bubble beyond the per-access stall.
- `abort_i` and the RESP cycle coinciding: abort wins; no write commit.

## Test plan
- Reset, WAIT_CYCLES=1: write 0xDEADBEEF to 0x1000_0010, then read 0x1000_0010.
  - Each access: `hold_o`=1 for 2 cycles; RESP on the 3rd cycle.
  - The read returns 0xDEADBEEF; `err_o`=0.
- WAIT_CYCLES=0: read 0x1000_0013 after writing 0x12345678 to 0x1000_0010.
  - Low bits are ignored; `rdata_o`=0x12345678 in the cycle after acceptance.
  - `hold_o` high for exactly 1 cycle.
- Out of range: read 0x0FFF_FFFC → `rdata_o`=0, `err_o`=1 for 1 cycle.
  - Write 0x1000_4000 (with DEPTH_WORDS=4096) → `err_o`=1 and no array change; a readback of index 0 is unchanged.
- Abort: WAIT_CYCLES=3, write 0xA5A5A5A5 to 0x1000_0020; assert `abort_i` in the 2nd WAIT cycle.
  - Next cycle is IDLE with `hold_o`=0, `err_o` stays 0.
  - A later read of 0x1000_0020 returns the old value.
- Reset mid-WAIT: drop `rst` to 0 during WAIT of a write.
  - `hold_o`, `rdata_o` and `err_o` go to 0 immediately; the write is not committed.
  - After release, the FSM is in IDLE and accepts a new request.
- Back-to-back reads of 0x1000_0000 and 0x1000_0004, with `req_i` held continuously: the second access is accepted in the IDLE cycle after the first RESP, and each returns its own word.
